// File: rtl/traffic_sensor_conditioner.sv
// rtl/traffic_sensor_conditioner.sv - loop-detector conditioning for roads A and B
// Each road is synchronised, debounced, gap-held and counted by an independent channel.

module traffic_sensor_channel #(
  parameter int DEB_CYC = 4,
  parameter int GAP_CYC = 8,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw,
  input  logic          cnt_clr,
  output logic          req,
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    OCCUPIED = 2'd1,
    GAP      = 2'd2
  } state_t;

  localparam logic [7:0]    DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic       sync1;
  logic       s;
  state_t     state;
  state_t     state_nx;
  logic [7:0] qcnt;
  logic [7:0] qcnt_nx;
  logic [7:0] gcnt;
  logic [7:0] gcnt_nx;
  logic       arrive;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
      qcnt  <= 8'd0;
      gcnt  <= 8'd0;
    end else begin
      state <= state_nx;
      qcnt  <= qcnt_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    qcnt_nx  = qcnt;
    gcnt_nx  = gcnt;
    arrive   = 1'b0;
    case (state)
      EMPTY: begin
        if (!s) begin
          qcnt_nx = 8'd0;
        end else if (qcnt == DEB_LAST) begin
          state_nx = OCCUPIED;
          qcnt_nx  = 8'd0;
          arrive   = 1'b1;
        end else begin
          qcnt_nx = qcnt + 8'd1;
        end
      end
      OCCUPIED: begin
        if (!s) begin
          state_nx = GAP;
          gcnt_nx  = 8'd1;
        end
      end
      GAP: begin
        // A vehicle reappearing inside the gap window is the same occupancy, not an arrival.
        if (s) begin
          state_nx = OCCUPIED;
          gcnt_nx  = 8'd0;
        end else if (gcnt == GAP_LAST) begin
          state_nx = EMPTY;
          gcnt_nx  = 8'd0;
        end else begin
          gcnt_nx = gcnt + 8'd1;
        end
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (arrive && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign req = (state != EMPTY);

endmodule

module traffic_sensor_conditioner #(
  parameter int DEB_CYC = 4,
  parameter int GAP_CYC = 8,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw_a,
  input  logic          raw_b,
  input  logic          cnt_clr,
  output logic          ta,
  output logic          tb,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  traffic_sensor_channel #(
    .DEB_CYC(DEB_CYC),
    .GAP_CYC(GAP_CYC),
    .CW     (CW)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_a),
    .cnt_clr(cnt_clr),
    .req    (ta),
    .cnt    (cnt_a)
  );

  traffic_sensor_channel #(
    .DEB_CYC(DEB_CYC),
    .GAP_CYC(GAP_CYC),
    .CW     (CW)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw_b),
    .cnt_clr(cnt_clr),
    .req    (tb),
    .cnt    (cnt_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb/tb_traffic_sensor_conditioner.sv - scoreboard bench for traffic_sensor_conditioner
module tb_traffic_sensor_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       raw_a = 1'b0;
  logic       raw_b = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       ta;
  logic       tb;
  logic [1:0] cnt_a;
  logic [1:0] cnt_b;

  typedef struct {
    logic       ta;
    logic       tb;
    logic [1:0] ca;
    logic [1:0] cb;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  traffic_sensor_conditioner #(
    .DEB_CYC(4),
    .GAP_CYC(8),
    .CW     (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .cnt_clr(cnt_clr),
    .ta     (ta),
    .tb     (tb),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    raw_a   = 1'b0;
    raw_b   = 1'b0;
    cnt_clr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    raw_a = 1'b1;
    raw_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.ta = 1'b0; e.tb = 1'b0; e.ca = 2'd0; e.cb = 2'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL reset_hold edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      e.ta = (k >= 5); e.tb = (k >= 5);
      e.ca = (k >= 5) ? 2'd1 : 2'd0; e.cb = e.ca;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
  endtask

  task automatic test_qualify();
    exp_t e;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      raw_a = (k < 3);
      e.ta = 1'b0; e.tb = 1'b0; e.ca = 2'd0; e.cb = 2'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL qualify_short edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
    do_reset();
    for (int k = 0; k < 11; k++) begin
      raw_a = (k < 4);
      e.ta = (k >= 5); e.tb = 1'b0;
      e.ca = (k >= 5) ? 2'd1 : 2'd0; e.cb = 2'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL qualify_full edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
  endtask

  task automatic test_gap_hold();
    exp_t e;
    do_reset();
    for (int k = 0; k < 23; k++) begin
      raw_a = (k < 10);
      e.ta = (k >= 5) && (k <= 18); e.tb = 1'b0;
      e.ca = (k >= 5) ? 2'd1 : 2'd0; e.cb = 2'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL gap_hold edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
  endtask

  task automatic test_gap_rearrival();
    exp_t e;
    do_reset();
    for (int k = 0; k < 43; k++) begin
      raw_a = (k < 10) || ((k >= 15) && (k < 20)) || (k >= 35);
      e.ta = ((k >= 5) && (k <= 28)) || (k >= 40); e.tb = 1'b0;
      e.ca = (k >= 40) ? 2'd2 : ((k >= 5) ? 2'd1 : 2'd0); e.cb = 2'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL gap_rearrival edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
  endtask

  task automatic test_saturation_clear();
    exp_t e;
    int   arrivals;
    do_reset();
    for (int k = 0; k < 89; k++) begin
      raw_b   = ((k % 16) < 4);
      cnt_clr = (k == 85);
      arrivals = (k >= 5) ? ((k - 5) / 16 + 1) : 0;
      e.ta = 1'b0; e.ca = 2'd0;
      e.tb = ((k % 16) >= 5) && ((k % 16) <= 12);
      e.cb = (k >= 85) ? 2'd0 : ((arrivals > 3) ? 2'd3 : 2'(arrivals));
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL saturation_clear edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
    cnt_clr = 1'b0;
  endtask

  task automatic test_independence();
    exp_t e;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      raw_a = (k < 6);
      raw_b = 1'b1;
      e.ta = (k >= 5) && (k <= 14); e.tb = (k >= 5);
      e.ca = (k >= 5) ? 2'd1 : 2'd0; e.cb = e.ca;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL independence edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      raw_b = 1'b1;
      reset = (k != 4);
      e.ta = 1'b0; e.ca = 2'd0;
      e.tb = (k >= 10); e.cb = (k >= 10) ? 2'd1 : 2'd0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({ta, tb, cnt_a, cnt_b} !== {e.ta, e.tb, e.ca, e.cb}) begin
        miscompares++;
        $display("FAIL reset_mid edge %0d: got ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d, expected ta=%0b tb=%0b cnt_a=%0d cnt_b=%0d",
                 k, ta, tb, cnt_a, cnt_b, e.ta, e.tb, e.ca, e.cb);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    tick();
    test_reset();
    test_qualify();
    test_gap_hold();
    test_gap_rearrival();
    test_saturation_clear();
    test_independence();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
